// File: rtl/dco_freq_lock_ctrl_if.sv
// Control/status bundle between the PLL top and the DCO frequency-lock controller.
// The clock and reset stay outside the bundle.
interface dco_freq_lock_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             osc;
    logic [CNT_W-1:0] div;
    logic [25:0]      trim;
    logic [4:0]       tval;
    logic [CNT_W-1:0] meas;
    logic             locked;

    modport master (
        output enable, osc, div,
        input  trim, tval, meas, locked
    );

    modport slave (
        input  enable, osc, div,
        output trim, tval, meas, locked
    );
endinterface

// File: rtl/dco_freq_lock_ctrl.sv
// Frequency-lock loop for the trimmable ring oscillator. It counts DCO cycles per
// reference period and steps a thermometer trim word toward the programmed ratio.
module dco_freq_lock_ctrl #(
    parameter int CNT_W      = 8,
    parameter int TVAL_MAX   = 26,
    parameter int TVAL_RESET = 13,
    parameter int DEADBAND   = 1,
    parameter int LOCK_N     = 4
) (
    input  logic              clock,
    input  logic              reset,
    dco_freq_lock_ctrl_if.slave bus
);
    localparam int SW = CNT_W + 2;
    localparam int LW = $clog2(LOCK_N + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [4:0]       TV_MAX   = 5'(TVAL_MAX);
    localparam logic [4:0]       TV_RST   = 5'(TVAL_RESET);
    localparam logic [SW-1:0]    DB       = SW'(DEADBAND);
    localparam logic [LW-1:0]    LOCK_TOP = LW'(LOCK_N);

    // Primary bit of every stage is applied before its secondary bit.
    function automatic logic [25:0] trim_decode(input logic [4:0] tv);
        logic [13:0] ones;
        logic [12:0] prim;
        logic [12:0] sec;
        if (tv <= 5'd13) begin
            ones = (14'd1 << tv) - 14'd1;
            prim = ones[12:0];
            sec  = 13'd0;
        end else begin
            ones = (14'd1 << (tv - 5'd13)) - 14'd1;
            prim = 13'h1FFF;
            sec  = ones[12:0];
        end
        return {sec, prim};
    endfunction

    logic [2:0]       sync_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] meas_r;
    logic [CNT_W-1:0] meas_prev_r;
    logic [1:0]       nval_r;
    logic             dec_r;
    logic [4:0]       tval_r;
    logic [LW-1:0]    lcnt_r;
    logic             locked_r;
    logic [25:0]      trim_r;

    logic             ev_s;
    logic [SW-1:0]    sum_s;
    logic [SW-1:0]    tgt_s;
    logic             fast_s;
    logic             slow_s;

    assign ev_s = sync_r[1] & ~sync_r[2];

    // Two-period sum against twice the ratio, widened so no term can overflow.
    always_comb begin
        sum_s  = {2'b00, meas_r} + {2'b00, meas_prev_r};
        tgt_s  = {1'b0, bus.div, 1'b0};
        fast_s = 1'b0;
        slow_s = 1'b0;
        if (sum_s > (tgt_s + DB)) begin
            fast_s = 1'b1;
        end else if ((sum_s + DB) < tgt_s) begin
            slow_s = 1'b1;
        end else begin
            fast_s = 1'b0;
            slow_s = 1'b0;
        end
    end

    // Reference synchroniser; keeps running while the loop is disabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], bus.osc};
        end
    end

    // Period measurement, step decision and lock counting.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r       <= {CNT_W{1'b0}};
            meas_r      <= {CNT_W{1'b0}};
            meas_prev_r <= {CNT_W{1'b0}};
            nval_r      <= 2'd0;
            dec_r       <= 1'b0;
            tval_r      <= TV_RST;
            lcnt_r      <= {LW{1'b0}};
        end else if (!bus.enable) begin
            cnt_r  <= {CNT_W{1'b0}};
            nval_r <= 2'd0;
            dec_r  <= 1'b0;
            lcnt_r <= {LW{1'b0}};
        end else begin
            // The first two events only prime meas/meas_prev with whole periods.
            dec_r <= ev_s && (nval_r == 2'd2);
            if (ev_s) begin
                meas_r      <= cnt_r;
                meas_prev_r <= meas_r;
                cnt_r       <= {{(CNT_W-1){1'b0}}, 1'b1};
                nval_r      <= (nval_r == 2'd2) ? 2'd2 : nval_r + 2'd1;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
            if (dec_r) begin
                if (fast_s) begin
                    lcnt_r <= {LW{1'b0}};
                    tval_r <= (tval_r == TV_MAX) ? tval_r : tval_r + 5'd1;
                end else if (slow_s) begin
                    lcnt_r <= {LW{1'b0}};
                    tval_r <= (tval_r == 5'd0) ? tval_r : tval_r - 5'd1;
                end else begin
                    lcnt_r <= (lcnt_r == LOCK_TOP) ? lcnt_r : lcnt_r + {{(LW-1){1'b0}}, 1'b1};
                end
            end else begin
                lcnt_r <= lcnt_r;
            end
        end
    end

    // Registered trim word and lock flag, one cycle behind tval/lcnt.
    always_ff @(posedge clock) begin
        if (reset) begin
            trim_r   <= trim_decode(TV_RST);
            locked_r <= 1'b0;
        end else if (!bus.enable) begin
            trim_r   <= trim_decode(tval_r);
            locked_r <= 1'b0;
        end else begin
            trim_r   <= trim_decode(tval_r);
            locked_r <= (lcnt_r == LOCK_TOP);
        end
    end

    assign bus.trim   = trim_r;
    assign bus.tval   = tval_r;
    assign bus.meas   = meas_r;
    assign bus.locked = locked_r;
endmodule
